// File: rtl/rca_adder.sv
// Registered ripple-carry adder: {cout,s} = a + b + cin, one cycle latency.
// Define RCA_OVF_EN to add the registered signed-overflow output ovf.

module rca_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    always_comb begin
        s  = a ^ b ^ ci;
        co = (a & b) | (a & ci) | (b & ci);
    end

endmodule

module rca_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             out_valid
`ifdef RCA_OVF_EN
    ,
    output logic             ovf
`endif
);

    // c[i] is the carry into bit i; c[WIDTH] is the carry out of the chain
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] sum;

    assign c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        rca_fa u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (sum[i]),
            .co (c[i+1])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s         <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                s    <= sum;
                cout <= c[WIDTH];
            end
        end
    end

`ifdef RCA_OVF_EN
    // Signed overflow: carry into the sign bit differs from carry out of it
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (in_valid) begin
            ovf <= c[WIDTH] ^ c[WIDTH-1];
        end
    end
`endif

endmodule

// File: tb/tb_rca_adder.sv
// Self-checking bench for rca_adder: directed vector table, corner sequences,
// and randomized checks of WIDTH=4 and WIDTH=16 against an arithmetic model.

module tb_rca_adder;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [3:0] s;
        logic       cout;
        logic       ovf;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        v4, c4, co4, ov4;
    logic [3:0]  a4, b4, s4;
    logic        v16, c16, co16, ov16;
    logic [15:0] a16, b16, s16;
`ifdef RCA_OVF_EN
    logic        f4, f16;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rca_adder #(.WIDTH(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v4),
        .a         (a4),
        .b         (b4),
        .cin       (c4),
        .s         (s4),
        .cout      (co4),
        .out_valid (ov4)
`ifdef RCA_OVF_EN
        ,
        .ovf       (f4)
`endif
    );

    rca_adder #(.WIDTH(16)) dut16 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v16),
        .a         (a16),
        .b         (b16),
        .cin       (c16),
        .s         (s16),
        .cout      (co16),
        .out_valid (ov16)
`ifdef RCA_OVF_EN
        ,
        .ovf       (f16)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer addition, signed range test for overflow
    function automatic void ref_add(input int w, input int unsigned a, input int unsigned b,
                                    input int unsigned c, output int unsigned s,
                                    output int unsigned co, output int unsigned ov);
        int unsigned total;
        int sa, sb, st;
        total = a + b + c;
        s     = total % (32'd1 << w);
        co    = total >> w;
        sa    = (a >= (32'd1 << (w - 1))) ? int'(a) - (1 << w) : int'(a);
        sb    = (b >= (32'd1 << (w - 1))) ? int'(b) - (1 << w) : int'(b);
        st    = sa + sb + int'(c);
        ov    = (st > (1 << (w - 1)) - 1 || st < -(1 << (w - 1))) ? 1 : 0;
    endfunction

    task automatic chk4(input string tag, input logic [3:0] es, input logic eco,
                        input logic eov, input logic ef);
        chk({tag, ".s"}, 32'(s4), 32'(es));
        chk({tag, ".cout"}, 32'(co4), 32'(eco));
        chk({tag, ".out_valid"}, 32'(ov4), 32'(eov));
`ifdef RCA_OVF_EN
        chk({tag, ".ovf"}, 32'(f4), 32'(ef));
`else
        if (ef === 1'bz) $display("unused %0b", ef);
`endif
    endtask

    initial begin
        vec_t tbl[7];
        int unsigned es, eco, eov, ef;
        int unsigned m4_s, m4_co, m4_f, m16_s, m16_co, m16_f;
        logic m4_v, m16_v;

        tbl[0] = '{4'b0110, 4'b1100, 1'b0, 4'b0010, 1'b1, 1'b0};
        tbl[1] = '{4'b1110, 4'b1000, 1'b0, 4'b0110, 1'b1, 1'b1};
        tbl[2] = '{4'b0111, 4'b1110, 1'b0, 4'b0101, 1'b1, 1'b0};
        tbl[3] = '{4'b0010, 4'b1001, 1'b0, 4'b1011, 1'b0, 1'b0};
        tbl[4] = '{4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0};
        tbl[5] = '{4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0};
        tbl[6] = '{4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1};

        rst = 1'b1; v4 = 1'b0; a4 = '0; b4 = '0; c4 = 1'b0;
        v16 = 1'b0; a16 = '0; b16 = '0; c16 = 1'b0;
        step();
        step();
        chk4("reset", 4'h0, 1'b0, 1'b0, 1'b0);
        chk("reset16.s", 32'(s16), 32'h0);
        chk("reset16.cout", 32'(co16), 32'h0);
        chk("reset16.out_valid", 32'(ov16), 32'h0);
        rst = 1'b0;

        // Directed table: each vector a one-cycle pulse followed by an idle hold cycle
        for (int i = 0; i < 7; i++) begin
            v4 = 1'b1; a4 = tbl[i].a; b4 = tbl[i].b; c4 = tbl[i].cin;
            step();
            chk4($sformatf("vec%0d", i), tbl[i].s, tbl[i].cout, 1'b1, tbl[i].ovf);
            v4 = 1'b0; a4 = ~tbl[i].a; b4 = 4'h5; c4 = ~tbl[i].cin;
            step();
            chk4($sformatf("hold%0d", i), tbl[i].s, tbl[i].cout, 1'b0, tbl[i].ovf);
        end

        // Back-to-back results, one per cycle
        v4 = 1'b1; a4 = 4'b1110; b4 = 4'b1000; c4 = 1'b0;
        step();
        chk4("b2b0", 4'b0110, 1'b1, 1'b1, 1'b1);
        a4 = 4'b0000; b4 = 4'b0000; c4 = 1'b0;
        step();
        chk4("b2b1", 4'b0000, 1'b0, 1'b1, 1'b0);

        // Unknown operands while idle must not disturb held outputs
        v4 = 1'b0; a4 = 'x; b4 = 'x; c4 = 1'bx;
        step();
        chk4("xidle0", 4'b0000, 1'b0, 1'b0, 1'b0);
        step();
        chk4("xidle1", 4'b0000, 1'b0, 1'b0, 1'b0);

        v4 = 1'b1; a4 = 4'b0111; b4 = 4'b0001; c4 = 1'b0;
        step();
        chk4("prerst", 4'b1000, 1'b0, 1'b1, 1'b1);

        // Reset wins over a valid input
        rst = 1'b1; a4 = 4'b1111; b4 = 4'b1111; c4 = 1'b1;
        step();
        chk4("rstmid", 4'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0; v4 = 1'b0;
        step();
        chk4("postrst", 4'h0, 1'b0, 1'b0, 1'b0);

        // Randomized: both widths in lockstep, model tracks hold behaviour
        m4_s = 0; m4_co = 0; m4_f = 0; m4_v = 1'b0;
        m16_s = 0; m16_co = 0; m16_f = 0; m16_v = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            v4  = ($urandom_range(0, 7) != 0);
            a4  = 4'($urandom);
            b4  = 4'($urandom);
            c4  = 1'($urandom);
            v16 = ($urandom_range(0, 7) != 0);
            a16 = 16'($urandom);
            b16 = 16'($urandom);
            c16 = 1'($urandom);
            if (i % 50 == 0) begin
                a16 = '1; b16 = '1; c16 = 1'b1;
            end
            m4_v = v4;
            if (v4) begin
                ref_add(4, 32'(a4), 32'(b4), 32'(c4), es, eco, ef);
                m4_s = es; m4_co = eco; m4_f = ef;
            end
            m16_v = v16;
            if (v16) begin
                ref_add(16, 32'(a16), 32'(b16), 32'(c16), es, eco, ef);
                m16_s = es; m16_co = eco; m16_f = ef;
            end
            step();
            eov = 32'(m4_v);
            chk4($sformatf("rnd4_%0d", i), 4'(m4_s), m4_co[0], eov[0], m4_f[0]);
            chk($sformatf("rnd16_%0d.s", i), 32'(s16), m16_s);
            chk($sformatf("rnd16_%0d.cout", i), 32'(co16), m16_co);
            chk($sformatf("rnd16_%0d.out_valid", i), 32'(ov16), 32'(m16_v));
`ifdef RCA_OVF_EN
            chk($sformatf("rnd16_%0d.ovf", i), 32'(f16), m16_f);
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
